// File: rtl/fp_adder_pipe.sv
// rtl/fp_adder_pipe.sv - four-stage pipelined floating-point adder/subtractor
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake for a, b, op_sub (0 = a+b, 1 = a-b)
//   out_valid/out_ready: result handshake for result, flag_invalid, flag_overflow
// Subnormal inputs and tiny results are flushed to signed zero; rounding is
// round-to-nearest-even.

module fp_adder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flag_invalid,
  output logic                 flag_overflow
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int LZ_W  = $clog2(SUM_W + 1);
  localparam int EW2   = EXP_W + 2;
  localparam logic [EXP_W-1:0] SAT_SH = EXP_W'(MAN_W + 3);

  // Pipeline state
  logic               r1_v, r2_v, r3_v, r_out_v;
  logic               r1_sl, r1_ss, r1_inv, r1_inf, r1_infs;
  logic [EXP_W-1:0]   r1_el, r1_es;
  logic [SIG_W-1:0]   r1_ml, r1_ms;
  logic               r2_sl, r2_ss, r2_inv, r2_inf, r2_infs;
  logic [EXP_W-1:0]   r2_el;
  logic [EXT_W-1:0]   r2_ml, r2_ms;
  logic               r3_sign, r3_inv, r3_inf, r3_infs;
  logic [EXP_W-1:0]   r3_el;
  logic [SUM_W-1:0]   r3_sum;
  logic [LZ_W-1:0]    r3_lzc;
  logic [W-1:0]       r_result;
  logic               r_inv, r_ovf;

  // One shared advance enable: the whole pipe freezes while the output is held.
  logic w_adv;
  assign w_adv     = !r_out_v || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_v;
  assign result    = r_result;
  assign flag_invalid  = r_inv;
  assign flag_overflow = r_ovf;

  // S1: unpack, classify, order by magnitude
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [MAN_W-1:0]     w_fa, w_fb;
  logic                 w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_swap;
  logic [EXP_W+MAN_W-1:0] w_key_a, w_key_b;
  logic [SIG_W-1:0]     w_sig_a, w_sig_b;
  logic [EXP_W-1:0]     w_exp_a, w_exp_b;

  assign w_ea = a[MAN_W +: EXP_W];
  assign w_eb = b[MAN_W +: EXP_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_fb = b[MAN_W-1:0];
  assign w_sa = a[EXP_W+MAN_W];
  assign w_sb = b[EXP_W+MAN_W] ^ op_sub;
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_a_inf  = (&w_ea) && !(|w_fa);
  assign w_b_inf  = (&w_eb) && !(|w_fb);
  assign w_a_zero = !(|w_ea);
  assign w_b_zero = !(|w_eb);
  // Flushed subnormals compare as zero magnitude.
  assign w_key_a = w_a_zero ? '0 : a[EXP_W+MAN_W-1:0];
  assign w_key_b = w_b_zero ? '0 : b[EXP_W+MAN_W-1:0];
  assign w_swap  = w_key_b > w_key_a;
  assign w_sig_a = w_a_zero ? '0 : {1'b1, w_fa};
  assign w_sig_b = w_b_zero ? '0 : {1'b1, w_fb};
  assign w_exp_a = w_a_zero ? '0 : w_ea;
  assign w_exp_b = w_b_zero ? '0 : w_eb;

  // S2: align the smaller significand, folding shifted-out bits into sticky
  logic [EXP_W-1:0] w_diff;
  logic [EXT_W-1:0] w_ext_s, w_shifted, w_lost_mask, w_al_s;
  logic             w_sticky;

  assign w_diff      = r1_el - r1_es;
  assign w_ext_s     = {r1_ms, 3'b000};
  assign w_shifted   = w_ext_s >> w_diff;
  assign w_lost_mask = ~({EXT_W{1'b1}} << w_diff);
  assign w_sticky    = |(w_ext_s & w_lost_mask);
  assign w_al_s      = (w_diff >= SAT_SH) ? {{(EXT_W-1){1'b0}}, |r1_ms}
                                          : {w_shifted[EXT_W-1:1], w_shifted[0] | w_sticky};

  // S3: effective add/subtract and leading-zero count
  logic [SUM_W-1:0] w_sum;
  logic [LZ_W-1:0]  w_lzc;

  assign w_sum = (r2_sl ^ r2_ss) ? ({1'b0, r2_ml} - {1'b0, r2_ms})
                                 : ({1'b0, r2_ml} + {1'b0, r2_ms});

  always_comb begin
    w_lzc = LZ_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (w_sum[i]) w_lzc = LZ_W'(SUM_W - 1 - i);
    end
  end

  // S4: normalise so the leading one sits at the carry position, then round
  logic [SUM_W-1:0]       w_norm;
  logic signed [EW2-1:0]  w_exp_n, w_exp_r;
  logic                   w_rup, w_carry;
  logic [SIG_W:0]         w_mant_r;
  logic [MAN_W-1:0]       w_frac;
  logic [W-1:0]           w_res;
  logic                   w_inv, w_ovf;

  assign w_norm   = r3_sum << r3_lzc;
  assign w_exp_n  = $signed({2'b00, r3_el}) + $signed(EW2'(1)) - $signed(EW2'(r3_lzc));
  assign w_rup    = w_norm[3] && (w_norm[2] || (|w_norm[1:0]) || w_norm[4]);
  assign w_mant_r = {1'b0, w_norm[SUM_W-1 -: SIG_W]} + (SIG_W+1)'(w_rup);
  assign w_carry  = w_mant_r[SIG_W];
  assign w_frac   = w_carry ? w_mant_r[SIG_W-1:1] : w_mant_r[MAN_W-1:0];
  assign w_exp_r  = w_exp_n + $signed(EW2'(w_carry));

  always_comb begin
    w_res = '0;
    w_inv = 1'b0;
    w_ovf = 1'b0;
    if (r3_inv) begin
      w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_inv = 1'b1;
    end else if (r3_inf) begin
      w_res = {r3_infs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r3_sum == '0) begin
      w_res = {r3_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (w_exp_r[EXP_W+1] || (w_exp_r == '0)) begin
      w_res = {r3_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (w_exp_r[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}}) begin
      w_res = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else begin
      w_res = {r3_sign, w_exp_r[EXP_W-1:0], w_frac};
    end
  end

  // Valid bits and output register; empty slots load zeros so flags drop with valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v     <= 1'b0;
      r2_v     <= 1'b0;
      r3_v     <= 1'b0;
      r_out_v  <= 1'b0;
      r_result <= '0;
      r_inv    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_adv) begin
      r1_v     <= in_valid;
      r2_v     <= r1_v;
      r3_v     <= r2_v;
      r_out_v  <= r3_v;
      r_result <= r3_v ? w_res : '0;
      r_inv    <= r3_v && w_inv;
      r_ovf    <= r3_v && w_ovf;
    end
  end

  // Datapath registers need no reset: they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_sl   <= w_swap ? w_sb : w_sa;
      r1_ss   <= w_swap ? w_sa : w_sb;
      r1_el   <= w_swap ? w_exp_b : w_exp_a;
      r1_es   <= w_swap ? w_exp_a : w_exp_b;
      r1_ml   <= w_swap ? w_sig_b : w_sig_a;
      r1_ms   <= w_swap ? w_sig_a : w_sig_b;
      r1_inv  <= w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb));
      r1_inf  <= w_a_inf || w_b_inf;
      r1_infs <= w_a_inf ? w_sa : w_sb;

      r2_sl   <= r1_sl;
      r2_ss   <= r1_ss;
      r2_el   <= r1_el;
      r2_ml   <= {r1_ml, 3'b000};
      r2_ms   <= w_al_s;
      r2_inv  <= r1_inv;
      r2_inf  <= r1_inf;
      r2_infs <= r1_infs;

      // An exact zero is negative only when both operands are negative.
      r3_sign <= (w_sum == '0) ? (r2_sl && r2_ss) : r2_sl;
      r3_el   <= r2_el;
      r3_sum  <= w_sum;
      r3_lzc  <= w_lzc;
      r3_inv  <= r2_inv;
      r3_inf  <= r2_inf;
      r3_infs <= r2_infs;
    end
  end

endmodule

// File: doc/fp_adder_pipe.md
FP_ADDER_PIPE -- requirements
Module: fp_adder_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b/op_sub present.
REQ-006 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE-754-style layout {sign, exp, frac}.
REQ-008 SHALL have port b  input  W  operand B, same layout.
REQ-009 SHALL have port op_sub  input  1  0 = A+B, 1 = A-B (B sign inverted).
REQ-010 SHALL have port out_valid  output  1  result/flags valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port result  output  W  rounded sum.
REQ-013 SHALL have port flag_invalid  output  1  NaN produced by invalid operation or NaN input.
REQ-014 SHALL have port flag_overflow  output  1  finite operands rounded to infinity.

Function
REQ-015 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-016 SHALL be a 4-stage pipeline: S1 unpack, special-case detect, magnitude compare, swap so larger magnitude first; S2 align smaller significand right by exponent difference, keeping guard, round, sticky bits; S3 add or subtract significands (effective op = sign_a XOR sign_b XOR op_sub), count leading zeros; S4 normalise, round, pack.
REQ-017 SHALL give latency of exactly 4 cycles from input transfer to out_valid when out_ready stays high.
REQ-018 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-019 SHALL stall all stages when out_valid && !out_ready; in_ready = !out_valid || out_ready; no stage drops or duplicates data.
REQ-020 SHALL hold result and flags stable while out_valid && !out_ready.
REQ-021 SHALL saturate alignment shift: exponent difference >= MAN_W+3 folds the entire smaller significand into sticky.
REQ-022 SHALL round to nearest, ties to even, using guard/round/sticky; carry out of rounding renormalises and increments exponent.
REQ-023 SHALL flush subnormal inputs to signed zero, and flush results with biased exponent <= 0 to zero carrying the result sign.
REQ-024 SHALL output +0 for an exact-zero result of operands with differing effective signs; (-0)+(-0) SHALL give -0.
REQ-025 SHALL output canonical quiet NaN {0, all-ones exp, 1, zeros} with flag_invalid=1 for any NaN operand or inf minus inf.
REQ-026 SHALL output correctly signed infinity when exactly one operand is infinite, or both infinite with equal effective sign; flags 0.
REQ-027 SHALL output signed infinity with flag_overflow=1 when the rounded exponent reaches all-ones from finite operands.
REQ-028 SHALL keep flags valid only alongside out_valid; flags are 0 when out_valid=0.

Reset
REQ-029 SHALL on rst clear all stage valid bits and drive out_valid=0, result=0, flag_invalid=0, flag_overflow=0, in_ready=1 in the following cycle.
REQ-030 SHALL discard in-flight operations on rst mid-operation; no result from before reset is ever presented.
REQ-031 SHALL take rst priority over a simultaneous input transfer, which is dropped.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-032 SHALL cover a=0x40490FDB, b=0x40490FDB, op_sub=0 -> result 0x40C90FDB after 4 cycles, flags 0.
REQ-033 SHALL cover a=0xC0490FDB, b=0x40490FDB, op_sub=0 -> 0x00000000; and a=b=0x80000000 -> 0x80000000.
REQ-034 SHALL cover a=0x7F800000, b=0xFF800000 -> 0x7FC00000, flag_invalid=1; a=0x7FC00001, b=0x40490FDB -> 0x7FC00000, flag_invalid=1; a=b=0xFF800000 -> 0xFF800000, flags 0.
REQ-035 SHALL cover a=b=0x7F7FFFFF -> 0x7F800000, flag_overflow=1; a=0x3F800000, b=0x33800000 (tie) -> 0x3F800000; a=0x3F800000, b=0x3F800000, op_sub=1 -> 0x00000000.
REQ-036 SHALL cover 8 back-to-back inputs with out_ready low 3 random cycles -> in_ready falls, all 8 results emerge in order, none lost or repeated.
REQ-037 SHALL cover rst asserted 2 cycles after issuing 3 operations -> out_valid stays 0 until new inputs arrive, first new result after 4 cycles.
